// File: rtl/mtsp_gpr_src_reader.sv
// mtsp_gpr_src_reader
// GPR array plus its source-read responder. A request (SRC_nEN low + SRC_ADDR)
// is answered two cycles later on SRC_DATA/SRC_VALID. Write-back traffic is
// forwarded, so a response reflects every write up to one cycle after the
// request. After reset a clear sequence zeroes the array, then READY rises.

module mtsp_gpr_src_reader #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 7
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  SRC_nEN,
   input  logic [ADDR_WIDTH-1:0] SRC_ADDR,
   input  logic                  WB_nEN,
   input  logic [ADDR_WIDTH-1:0] WB_ADDR,
   input  logic [DATA_WIDTH-1:0] WB_DATA,
   output logic [DATA_WIDTH-1:0] SRC_DATA,
   output logic                  SRC_VALID,
   output logic                  READY
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clr_cnt;
   logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;

   logic                  w_wr_en;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [DATA_WIDTH-1:0] w_wr_data;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  r_a_nen;
   logic [ADDR_WIDTH-1:0] r_a_addr;
   logic [DATA_WIDTH-1:0] w_rd_data;

   logic [DATA_WIDTH-1:0] r_src_data;
   logic                  r_src_valid;
   logic                  r_ready;

   // State register and clear counter
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state   <= ST_INIT;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   // Next state and array write port: clear writes in INIT, write-back in RUN
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      w_wr_en       = 1'b0;
      w_wr_addr     = WB_ADDR;
      w_wr_data     = WB_DATA;
      case (r_state)
         ST_INIT: begin
            w_wr_en       = 1'b1;
            w_wr_addr     = r_clr_cnt;
            w_wr_data     = '0;
            w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
            if (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_wr_en = ~WB_nEN;
         end
      endcase
   end

   // Register array; contents are defined by the clear sequence, not by reset
   always_ff @(posedge CLK) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= w_wr_data;
      end
   end

   // Stage A: capture the request
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_a_nen  <= 1'b1;
         r_a_addr <= '0;
      end else begin
         r_a_nen  <= SRC_nEN;
         r_a_addr <= SRC_ADDR;
      end
   end

   // Stage B read: zero while clearing, else bypass a same-cycle write to the same full address
   always_comb begin
      w_rd_data = r_mem[r_a_addr];
      if (r_state == ST_INIT) begin
         w_rd_data = '0;
      end else if (w_wr_en && (w_wr_addr == r_a_addr)) begin
         w_rd_data = w_wr_data;
      end
   end

   // Stage B output registers; data holds when no request is answered
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_src_data  <= '0;
         r_src_valid <= 1'b0;
         r_ready     <= 1'b0;
      end else begin
         r_src_valid <= ~r_a_nen;
         if (!r_a_nen) begin
            r_src_data <= w_rd_data;
         end
         r_ready <= (r_state == ST_RUN);
      end
   end

   assign SRC_DATA  = r_src_data;
   assign SRC_VALID = r_src_valid;
   assign READY     = r_ready;

endmodule

// File: tb/tb_mtsp_gpr_src_reader.sv
// Testbench for mtsp_gpr_src_reader: cycle-stepped driver with a reference
// model of the register array. Requests are queued when driven, resolved into
// expected responses once the following cycle's write is known, and compared
// when the response is due.

module tb_mtsp_gpr_src_reader;

   localparam int DW    = 32;
   localparam int AW    = 7;
   localparam int DEPTH = 128;

   logic          CLK = 1'b0;
   logic          nRST = 1'b1;
   logic          SRC_nEN = 1'b1;
   logic [AW-1:0] SRC_ADDR = '0;
   logic          WB_nEN = 1'b1;
   logic [AW-1:0] WB_ADDR = '0;
   logic [DW-1:0] WB_DATA = '0;
   logic [DW-1:0] SRC_DATA;
   logic          SRC_VALID;
   logic          READY;

   mtsp_gpr_src_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .SRC_nEN   (SRC_nEN),
      .SRC_ADDR  (SRC_ADDR),
      .WB_nEN    (WB_nEN),
      .WB_ADDR   (WB_ADDR),
      .WB_DATA   (WB_DATA),
      .SRC_DATA  (SRC_DATA),
      .SRC_VALID (SRC_VALID),
      .READY     (READY)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic          v;
      logic [AW-1:0] a;
   } req_t;

   typedef struct packed {
      logic          v;
      logic [DW-1:0] d;
   } rsp_t;

   req_t          req_q[$];
   rsp_t          exp_q[$];
   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] m_last;
   int            k;
   int            n_chk = 0;
   int            n_err = 0;

   task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d after reset)", tag, act, expv, k);
      end
   endtask

   task automatic model_clear();
      req_q.delete();
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_last = '0;
      k = 0;
   endtask

   // One clock cycle: drive inputs, advance the model, compare the response due now
   task automatic step(input logic s_nen, input logic [AW-1:0] s_addr,
                       input logic w_nen, input logic [AW-1:0] w_addr, input logic [DW-1:0] w_data);
      req_t r;
      rsp_t e;
      SRC_nEN  = s_nen;
      SRC_ADDR = s_addr;
      WB_nEN   = w_nen;
      WB_ADDR  = w_addr;
      WB_DATA  = w_data;
      if (!w_nen && k >= DEPTH) m_mem[w_addr] = w_data;
      e.v = 1'b0;
      e.d = m_last;
      if (req_q.size() > 0) begin
         r = req_q.pop_front();
         if (r.v) begin
            e.v    = 1'b1;
            e.d    = (k < DEPTH) ? '0 : m_mem[r.a];
            m_last = e.d;
         end
      end
      exp_q.push_back(e);
      r.v = ~s_nen;
      r.a = s_addr;
      req_q.push_back(r);
      @(posedge CLK);
      #1;
      k++;
      e = exp_q.pop_front();
      chk("src_valid", DW'(SRC_VALID), DW'(e.v));
      chk("src_data", SRC_DATA, e.d);
      chk("ready", DW'(READY), DW'(k > DEPTH));
   endtask

   task automatic idle();
      step(1'b1, '0, 1'b1, '0, '0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      step(1'b0, a, 1'b1, '0, '0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      step(1'b1, '0, 1'b0, a, d);
   endtask

   // Assert reset now, check async output clear, release between edges
   task automatic do_reset();
      nRST    = 1'b0;
      SRC_nEN = 1'b1;
      WB_nEN  = 1'b1;
      #1;
      chk("rst_src_data", SRC_DATA, '0);
      chk("rst_src_valid", DW'(SRC_VALID), '0);
      chk("rst_ready", DW'(READY), '0);
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
      model_clear();
   endtask

   // Run through the clear sequence with optional probes, ending with READY high
   task automatic run_clear(input int rd_at, input logic [AW-1:0] rd_addr,
                            input int wr_at, input logic [AW-1:0] wr_addr, input logic [DW-1:0] wr_data);
      for (int i = 0; i < DEPTH + 2; i++) begin
         step(!(i == rd_at), rd_addr, !(i == wr_at), wr_addr, wr_data);
      end
   endtask

   function automatic logic [AW-1:0] pick_addr();
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) a = a | AW'(7'h40);
      return a;
   endfunction

   initial begin
      model_clear();
      #2;
      do_reset();

      // Clear sequence; read 0x7F at cycle 5, INIT write to 0x05 must be dropped
      run_clear(5, 7'h7F, 20, 7'h05, 32'hFFFF_FFFF);

      // Bank separation: write bank 0 index 5 while reading bank 1 index 5
      step(1'b0, 7'h25, 1'b0, 7'h05, 32'hA5A5_A5A5);
      idle();
      idle();
      rd(7'h05);
      idle();
      idle();

      // Basic write then read
      wr(7'h25, 32'hDEAD_BEEF);
      idle();
      rd(7'h25);
      idle();
      idle();

      // Forwarding at t and t+1, write at t+2 invisible to first read, visible to second
      step(1'b0, 7'h03, 1'b0, 7'h03, 32'h1111_1111);
      wr(7'h03, 32'h2222_2222);
      step(1'b0, 7'h03, 1'b0, 7'h03, 32'h3333_3333);
      idle();
      idle();

      // Back-to-back stream
      for (int i = 0; i < 16; i++) wr(AW'(i), DW'(i + 32'h100));
      for (int i = 0; i < 16; i++) rd(AW'(i));
      idle();
      idle();

      // Mixed random traffic across two banks
      for (int i = 0; i < 80; i++) begin
         step(1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)), pick_addr(), DW'($urandom));
      end
      idle();
      idle();

      // Reset mid-stream with reads in flight
      rd(7'h25);
      rd(7'h0A);
      SRC_nEN  = 1'b0;
      SRC_ADDR = 7'h26;
      #2;
      do_reset();

      // Re-clear; write during INIT must not land
      run_clear(-1, '0, 10, 7'h25, 32'h1234_5678);
      rd(7'h25);
      rd(7'h0A);
      rd(7'h03);
      idle();
      idle();

      if (req_q.size() != 1) begin
         n_err++;
         $display("FAIL req_queue: got %0d entries expected 1", req_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
